// File: rtl/dma_pkg.sv
// Shared constants for the DMA FIFO block: default payload width and read-mode encodings.
package dma_pkg;

   localparam int DMA_DATA_WIDTH = 32;

   localparam int FIFO_MODE_STD  = 0;
   localparam int FIFO_MODE_FWFT = 1;

endpackage

// File: rtl/fifo_ram.sv
// Storage for dma_fifo: 1-write/1-read register array, asynchronous read, no reset.
module fifo_ram import dma_pkg::*; #(
   parameter int DATA_WIDTH = DMA_DATA_WIDTH,
   parameter int DEPTH      = 16,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/dma_fifo.sv
// Synchronous DMA FIFO with wrap-bit pointers, status/almost flags, sticky errors and
// selectable registered or first-word-fall-through read data.
module dma_fifo import dma_pkg::*; #(
   parameter int DATA_WIDTH = DMA_DATA_WIDTH,
   parameter int DEPTH      = 16,
   parameter int AF_THRESH  = DEPTH - 2,
   parameter int AE_THRESH  = 2,
   parameter int FWFT       = FIFO_MODE_STD,
   localparam int AW        = $clog2(DEPTH),
   localparam int CW        = AW + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  w_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  r_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [CW-1:0]         count,
   output logic                  overflow,
   output logic                  underflow
);

   logic [CW-1:0]         wr_ptr;
   logic [CW-1:0]         rd_ptr;
   logic [CW-1:0]         cnt;
   logic                  ovf_q;
   logic                  udf_q;
   logic                  wr_ok;
   logic                  rd_ok;
   logic [DATA_WIDTH-1:0] head;

   // Handshake: w_en is a request accepted only while !full, r_en a request accepted
   // only while !empty; a refused request has no effect other than its sticky error flag.
   assign wr_ok = w_en && !full;
   assign rd_ok = r_en && !empty;

   assign full         = (cnt == CW'(DEPTH));
   assign empty        = (cnt == '0);
   assign almost_full  = (32'(cnt) >= 32'(AF_THRESH));
   assign almost_empty = (32'(cnt) <= 32'(AE_THRESH));
   assign count        = cnt;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

   fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (wr_ok && !rst && !flush),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (data_in),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (head)
   );

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         ovf_q  <= 1'b0;
         udf_q  <= 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + CW'(1);
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + CW'(1);
         end
         cnt   <= cnt + CW'(wr_ok) - CW'(rd_ok);
         ovf_q <= ovf_q | (w_en && full);
         udf_q <= udf_q | (r_en && empty);
      end
   end

   generate
      if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
         // Head entry shows through while anything is stored; zero otherwise so a flush reads as 0.
         assign data_out = empty ? '0 : head;
      end else begin : g_std
         logic [DATA_WIDTH-1:0] dout_q;

         always_ff @(posedge clk) begin
            if (rst || flush) begin
               dout_q <= '0;
            end else if (rd_ok) begin
               dout_q <= head;
            end
         end

         assign data_out = dout_q;
      end
   endgenerate

endmodule

// File: doc/dma_fifo.md
DMA_FIFO -- requirements
Module: dma_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: payload width in bits, >=1.
REQ-002 SHALL have parameter DEPTH, default 16: entry count, power of two, >=2.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-2: almost_full asserts at count >= AF_THRESH.
REQ-004 SHALL have parameter AE_THRESH, default 2: almost_empty asserts at count <= AE_THRESH.
REQ-005 SHALL have parameter FWFT, default 0: 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port flush  input  1  synchronous clear of contents and error flags.
REQ-009 SHALL have port w_en  input  1  write request.
REQ-010 SHALL have port data_in  input  DATA_WIDTH  write data.
REQ-011 SHALL have port r_en  input  1  read request / pop.
REQ-012 SHALL have port data_out  output  DATA_WIDTH  read data.
REQ-013 SHALL have port full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  stored entries, 0..DEPTH.
REQ-015 SHALL have port overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 SHALL hold DEPTH entries: pointers are $clog2(DEPTH)+1 bits, with the MSB as wrap bit.
REQ-017 SHALL accept a write iff w_en && !full; data is stored at the write pointer, which then increments modulo 2*DEPTH.
REQ-018 SHALL accept a read iff r_en && !empty; the read pointer increments.
REQ-019 SHALL, with FWFT=0, register data_out with the popped entry one cycle after an accepted read; it holds otherwise.
REQ-020 SHALL, with FWFT=1, drive data_out with the head entry whenever !empty, popped by an accepted read; data_out is don't-care when empty.
REQ-021 SHALL perform both operations on the same cycle when both are accepted; count is unchanged.
REQ-022 SHALL, when full with w_en && r_en both high, accept the read and reject the write; count decrements.
REQ-023 SHALL, when empty with w_en && r_en both high, accept the write and reject the read; count increments.
REQ-024 SHALL derive full=(count==DEPTH), empty=(count==0), and the almost flags from registered count only.
REQ-025 SHALL set overflow on any cycle with w_en && full, and underflow on any cycle with r_en && empty; both stay set until rst or flush.
REQ-026 SHALL give flush priority over w_en/r_en in the same cycle: pointers, count and errors clear, no read or write occurs, and data_out becomes 0.
REQ-027 SHALL preserve FIFO order across pointer wrap-around indefinitely.

Reset
REQ-028 SHALL, on rst high at a clock edge, set pointers=0, count=0, data_out=0, empty=1, full=0, almost_empty=1, almost_full=(AF_THRESH==0), overflow=0, underflow=0.
REQ-029 SHALL give rst priority over flush, w_en and r_en, including mid-operation; storage contents are not reset.

Structure
REQ-030 SHALL take shared constants (default DATA_WIDTH, mode encodings FIFO_MODE_STD/FIFO_MODE_FWFT) from package dma_pkg.
REQ-031 SHALL place storage in one sub-module, fifo_ram: a 1-write/1-read register array with asynchronous read and no reset.

Verification (DEPTH=4, DATA_WIDTH=8, AF_THRESH=3, AE_THRESH=1 unless stated)
REQ-032 SHALL cover fill: writing 0x11,0x22,0x33,0x44 -> count 1..4; almost_empty drops at count 2; almost_full at 3; full at 4; a fifth write of 0x55 -> overflow=1, count stays 4.
REQ-033 SHALL cover drain with FWFT=0: four reads -> data_out 0x11,0x22,0x33,0x44, each one cycle after r_en; empty=1 after the fourth; an extra read -> underflow=1, data_out holds 0x44.
REQ-034 SHALL cover steady state: at count=2, w_en and r_en high for 8 cycles with data 0x01..0x08 -> count stays 2, and outputs are the two preloaded values then 0x01..0x06 in order across wrap.
REQ-035 SHALL cover full plus both: at full with w_en=1 (0x99) and r_en=1 -> 0x11 read, 0x99 dropped, overflow=1, count=3.
REQ-036 SHALL cover FWFT=1: writing 0xA5 into an empty FIFO -> data_out=0xA5 the next cycle with r_en=0; one r_en pulse -> empty=1, count=0.
REQ-037 SHALL cover flush: flush with w_en=1 at count=3 and overflow=1 -> next cycle count=0, empty=1, overflow=0, data_out=0, write ignored; rst asserted the same way gives identical results.
